// File: rtl/dsp48a1_pkg.sv
// Shared types and constants for the DSP48A1 multiply-accumulate sequencer.
// Contents: FSM state enum, operand tag struct, slice opmode encodings,
// datapath widths and the opmode select helper.
package dsp48a1_pkg;

  localparam int unsigned A_W = 18;
  localparam int unsigned P_W = 48;

  // OPMODE = {pre-add ctl[7:4], Z[3:2], X[1:0]}
  localparam logic [7:0] OPM_FIRST = 8'h0D;  // X=M, Z=C: P = bias + a*b
  localparam logic [7:0] OPM_ACC   = 8'h09;  // X=M, Z=P: P += a*b
  localparam logic [7:0] OPM_HOLD  = 8'h08;  // X=0, Z=P: P holds

  typedef enum logic [1:0] {
    StIdle,
    StFeed,
    StDrain,
    StDone
  } state_e;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  function automatic logic [7:0] sel_opmode(input logic valid, input logic first);
    if (!valid) begin
      return OPM_HOLD;
    end
    return first ? OPM_FIRST : OPM_ACC;
  endfunction

endpackage

// File: rtl/dsp48a1_mac_sched_if.sv
// Job, operand-stream and result bundle of the MAC sequencer.
// master: producer/consumer side (drives start/len/bias, operands, res_ready).
// slave : sequencer side (drives busy, in_ready, res_valid, res_data).
interface dsp48a1_mac_sched_if
  import dsp48a1_pkg::*;
#(
  parameter int unsigned LEN_W = 8
) ();

  logic             start;
  logic [LEN_W-1:0] len;
  logic [P_W-1:0]   bias;
  logic             busy;

  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   in_a;
  logic [A_W-1:0]   in_b;

  logic             res_valid;
  logic             res_ready;
  logic [P_W-1:0]   res_data;

  modport master (
    output start, len, bias, in_valid, in_a, in_b, res_ready,
    input  busy, in_ready, res_valid, res_data
  );

  modport slave (
    input  start, len, bias, in_valid, in_a, in_b, res_ready,
    output busy, in_ready, res_valid, res_data
  );

endinterface

// File: rtl/dsp_tag_pipe.sv
// Tag delay line tracking each operand pair through the DSP48A1 pipeline.
// Ports: CLK, RST (async active-high), tag_in (tag of the pair being registered
// onto dsp_a/dsp_b), opmode (slice opmode for the tag at stage OP_DLY),
// last_done (final-beat tag has reached stage LAT, i.e. its sum is on P).
module dsp_tag_pipe
  import dsp48a1_pkg::*;
#(
  parameter int unsigned OP_DLY = 1,
  parameter int unsigned LAT    = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  tag_t       tag_in,
  output logic [7:0] opmode,
  output logic       last_done
);

  // stage_q[0] is aligned with dsp_a/dsp_b; stage_q[k] lags it by k cycles.
  tag_t stage_q [LAT+1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i <= LAT; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_in;
      for (int unsigned i = 1; i <= LAT; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign opmode    = sel_opmode(stage_q[OP_DLY].valid, stage_q[OP_DLY].first);
  assign last_done = stage_q[LAT].valid && stage_q[LAT].last;

endmodule

// File: rtl/dsp48a1_mac_sched.sv
// Sequencer driving one DSP48A1 slice as a signed multiply-accumulate engine.
// A job (start, len, bias) streams len operand pairs through bus.in_*; the
// result bias + sum(a*b) (mod 2^48) is returned on bus.res_*.
// Ports: CLK, RST (async active-high), bus (job/stream/result, slave side),
// dsp_* slice controls and operands, dsp_p slice P output.
module dsp48a1_mac_sched
  import dsp48a1_pkg::*;
#(
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned OP_DLY = 1,
  parameter int unsigned LAT    = 3
) (
  input  logic                CLK,
  input  logic                RST,
  dsp48a1_mac_sched_if.slave  bus,
  output logic [A_W-1:0]      dsp_a,
  output logic [A_W-1:0]      dsp_b,
  output logic [A_W-1:0]      dsp_d,
  output logic [P_W-1:0]      dsp_c,
  output logic [7:0]          dsp_opmode,
  output logic                dsp_carryin,
  output logic                dsp_ce,
  output logic                dsp_rst,
  input  logic [P_W-1:0]      dsp_p
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [P_W-1:0]   res_data_q;
  logic             accept;
  logic             take_job;
  logic             last_done;
  logic             in_ready;
  logic             res_valid;
  tag_t             tag_in;

  assign accept   = bus.in_valid && (state_q == StFeed);
  assign take_job = bus.start && (state_q == StIdle);

  always_comb begin
    tag_in       = '0;
    tag_in.valid = accept;
    tag_in.first = accept && (cnt_q == '0);
    tag_in.last  = accept && (cnt_q == len_q - LEN_W'(1));
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    dsp_ce    = 1'b0;
    dsp_rst   = 1'b0;
    unique case (state_q)
      StIdle: begin
        dsp_rst = 1'b1;
        if (bus.start) begin
          state_d = (bus.len == '0) ? StDone : StFeed;
        end
      end
      StFeed: begin
        dsp_ce   = 1'b1;
        in_ready = 1'b1;
        if (accept && (cnt_q == len_q - LEN_W'(1))) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        dsp_ce = 1'b1;
        if (last_done) begin
          state_d = StDone;
        end
      end
      StDone: begin
        dsp_rst   = 1'b1;
        res_valid = 1'b1;
        if (bus.res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      len_q      <= '0;
      cnt_q      <= '0;
      dsp_a      <= '0;
      dsp_b      <= '0;
      dsp_c      <= '0;
      res_data_q <= '0;
    end else begin
      state_q <= state_d;
      // Non-accept cycles feed zeros so bubbles contribute nothing.
      dsp_a   <= accept ? bus.in_a : '0;
      dsp_b   <= accept ? bus.in_b : '0;
      if (take_job) begin
        len_q <= bus.len;
        cnt_q <= '0;
        if (bus.len == '0) begin
          res_data_q <= bus.bias;
        end else begin
          dsp_c <= bus.bias;
        end
      end
      if (accept) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
      if ((state_q == StDrain) && last_done) begin
        res_data_q <= dsp_p;
      end
    end
  end

  dsp_tag_pipe #(
    .OP_DLY (OP_DLY),
    .LAT    (LAT)
  ) u_tag_pipe (
    .CLK       (CLK),
    .RST       (RST),
    .tag_in    (tag_in),
    .opmode    (dsp_opmode),
    .last_done (last_done)
  );

  assign dsp_d         = '0;
  assign dsp_carryin   = 1'b0;
  assign bus.busy      = (state_q != StIdle);
  assign bus.in_ready  = in_ready;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_data_q;

endmodule

// File: tb/tb_dsp48a1_mac_sched.sv
// Self-checking bench: behavioural DSP48A1 slice model (A1/B1, MREG, OPMODEREG,
// PREG) closes the loop; a scoreboard queue holds hand-computed results and a
// monitor compares them on each result handshake.
module tb_dsp48a1_mac_sched;
  import dsp48a1_pkg::*;

  localparam int unsigned LEN_W = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  dsp48a1_mac_sched_if #(.LEN_W(LEN_W)) bus ();

  logic [17:0] dsp_a, dsp_b, dsp_d;
  logic [47:0] dsp_c, dsp_p;
  logic [7:0]  dsp_opmode;
  logic        dsp_carryin, dsp_ce, dsp_rst;

  dsp48a1_mac_sched #(
    .LEN_W  (LEN_W),
    .OP_DLY (1),
    .LAT    (3)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .bus         (bus),
    .dsp_a       (dsp_a),
    .dsp_b       (dsp_b),
    .dsp_d       (dsp_d),
    .dsp_c       (dsp_c),
    .dsp_opmode  (dsp_opmode),
    .dsp_carryin (dsp_carryin),
    .dsp_ce      (dsp_ce),
    .dsp_rst     (dsp_rst),
    .dsp_p       (dsp_p)
  );

  // Slice model.
  logic signed [17:0] a1, b1;
  logic signed [35:0] m_r;
  logic [7:0]         opm_r;
  logic [47:0]        p_r, x_mux, z_mux;

  always_comb begin
    x_mux = (opm_r[1:0] == 2'b01) ? {{12{m_r[35]}}, m_r} : 48'd0;
    case (opm_r[3:2])
      2'b11:   z_mux = dsp_c;
      2'b10:   z_mux = p_r;
      default: z_mux = 48'd0;
    endcase
  end

  always @(posedge CLK) begin
    if (dsp_rst) begin
      a1 <= '0; b1 <= '0; m_r <= '0; opm_r <= '0; p_r <= '0;
    end else if (dsp_ce) begin
      a1    <= dsp_a;
      b1    <= dsp_b;
      m_r   <= a1 * b1;
      opm_r <= dsp_opmode;
      p_r   <= x_mux + z_mux;
    end
  end
  assign dsp_p = p_r;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [47:0] data;
    int          exp_cyc;
  } exp_t;
  exp_t sb_q[$];

  int checks   = 0;
  int failures = 0;

  logic [17:0] va [8];
  logic [17:0] vb [8];

  task automatic chk(input string name, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: latency on the rising res_valid, data on the handshake.
  initial begin : monitor
    logic rv_prev;
    exp_t e;
    rv_prev = 1'b0;
    forever begin
      @(negedge CLK);
      #1;
      if (bus.res_valid && !rv_prev) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result got=%h exp=none", bus.res_data);
        end else if (sb_q[0].exp_cyc >= 0) begin
          chk("res_latency", 48'(cyc), 48'(sb_q[0].exp_cyc));
        end
      end
      if (bus.res_valid && bus.res_ready && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("res_data", bus.res_data, e.data);
      end
      rv_prev = bus.res_valid;
    end
  end

  task automatic wait_idle(input logic ce0);
    int bound;
    bound = 0;
    while (bus.busy && bound < 100) begin
      if (ce0) chk("ce_len0", 48'(dsp_ce), 48'd0);
      @(negedge CLK);
      bound++;
    end
    if (bound >= 100) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout got=busy exp=idle");
    end
  endtask

  task automatic run_job(input logic [47:0] bias, input int n, input int gap,
                         input logic [47:0] exp, input int lat, input logic ce0,
                         input logic do_wait);
    int bound;
    @(negedge CLK);
    bus.start = 1'b1;
    bus.len   = LEN_W'(n);
    bus.bias  = bias;
    sb_q.push_back('{data: exp, exp_cyc: (lat >= 0) ? cyc + lat : -1});
    if (ce0) chk("ce_len0", 48'(dsp_ce), 48'd0);
    @(negedge CLK);
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (gap) @(negedge CLK);
      bus.in_valid = 1'b1;
      bus.in_a     = va[i];
      bus.in_b     = vb[i];
      bound = 0;
      while (!bus.in_ready && bound < 50) begin
        @(negedge CLK);
        bound++;
      end
      if (bound >= 50) begin
        checks++;
        failures++;
        $display("FAIL in_ready_timeout got=0 exp=1");
      end
      @(negedge CLK);
      bus.in_valid = 1'b0;
    end
    if (do_wait) wait_idle(ce0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int bound;
    bus.start = 1'b0; bus.len = '0; bus.bias = '0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
    bus.res_ready = 1'b1;

    repeat (3) @(negedge CLK);
    chk("rst_busy", 48'(bus.busy), 48'd0);
    chk("rst_in_ready", 48'(bus.in_ready), 48'd0);
    chk("rst_res_valid", 48'(bus.res_valid), 48'd0);
    chk("rst_dsp_ce", 48'(dsp_ce), 48'd0);
    chk("rst_dsp_rst", 48'(dsp_rst), 48'd1);
    chk("rst_dsp_a", 48'(dsp_a), 48'd0);
    chk("rst_dsp_c", dsp_c, 48'd0);
    chk("rst_res_data", bus.res_data, 48'd0);
    chk("rst_opmode", 48'(dsp_opmode), 48'h08);
    RST = 1'b0;

    // 1 + 10*10
    va[0] = 18'd10; vb[0] = 18'd10;
    run_job(48'd1, 1, 0, 48'd101, 6, 1'b0, 1'b1);

    // 100 - 6 + 35, continuous then with 2-cycle gaps
    va[0] = 18'd10; vb[0] = 18'd10;
    va[1] = 18'd2;  vb[1] = 18'(-3);
    va[2] = 18'd7;  vb[2] = 18'd5;
    run_job(48'd0, 3, 0, 48'd129, 8, 1'b0, 1'b1);
    run_job(48'd0, 3, 2, 48'd129, 12, 1'b0, 1'b1);

    // len == 0 returns the bias; slice never enabled
    run_job(48'd42, 0, 0, 48'd42, 1, 1'b1, 1'b1);

    // wrap and most-negative product
    va[0] = 18'd1; vb[0] = 18'd1;
    run_job(48'hFFFF_FFFF_FFFF, 1, 0, 48'd0, 6, 1'b0, 1'b1);
    va[0] = 18'h20000; vb[0] = 18'h20000;
    run_job(48'd0, 1, 0, 48'h0004_0000_0000, 6, 1'b0, 1'b1);

    // Backpressure in DONE with start pulses that must be ignored
    bus.res_ready = 1'b0;
    va[0] = 18'd2; vb[0] = 18'd3;
    run_job(48'd5, 1, 0, 48'd11, 6, 1'b0, 1'b0);
    bound = 0;
    while (!bus.res_valid && bound < 50) begin
      @(negedge CLK);
      bound++;
    end
    for (int i = 0; i < 5; i++) begin
      bus.start = i[0];
      bus.len   = 8'd2;
      bus.bias  = 48'd99;
      chk("bp_res_valid", 48'(bus.res_valid), 48'd1);
      chk("bp_res_data", bus.res_data, 48'd11);
      @(negedge CLK);
    end
    bus.start     = 1'b1;
    bus.res_ready = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    chk("bp_start_ignored", 48'(bus.busy), 48'd0);

    // Normal job after backpressure: 20 - 6
    va[0] = 18'd4;     vb[0] = 18'd5;
    va[1] = 18'(-1);   vb[1] = 18'd6;
    run_job(48'd0, 2, 0, 48'd14, 7, 1'b0, 1'b1);

    // Reset mid-job after 2 of 4 beats
    @(negedge CLK);
    bus.start = 1'b1; bus.len = 8'd4; bus.bias = 48'd7;
    @(negedge CLK);
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1; bus.in_a = 18'd9; bus.in_b = 18'd9;
      @(negedge CLK);
    end
    bus.in_valid = 1'b0;
    RST = 1'b1;
    #1;
    chk("mid_rst_busy", 48'(bus.busy), 48'd0);
    chk("mid_rst_in_ready", 48'(bus.in_ready), 48'd0);
    chk("mid_rst_dsp_ce", 48'(dsp_ce), 48'd0);
    chk("mid_rst_dsp_rst", 48'(dsp_rst), 48'd1);
    chk("mid_rst_dsp_a", 48'(dsp_a), 48'd0);
    chk("mid_rst_dsp_c", dsp_c, 48'd0);
    chk("mid_rst_opmode", 48'(dsp_opmode), 48'h08);
    @(negedge CLK);
    RST = 1'b0;

    va[0] = 18'd3; vb[0] = 18'd4;
    run_job(48'd0, 1, 0, 48'd12, 6, 1'b0, 1'b1);

    repeat (4) @(negedge CLK);
    chk("sb_empty", 48'(sb_q.size()), 48'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
